audio_sample_player: RTL and testbench

- Consumer at the far end of the register-file audio path.
- Captures 11-bit samples the processor writes into R6, using the R14 flag as a write strobe, and buffers them in a small FIFO.
- Releases buffered samples at a fixed sample rate and drives a 1-bit PWM audio output.
- Returns a one-cycle acknowledge per accepted sample so firmware can pace its writes.

---
 rtl/audio_sample_player.sv | 118 +++++++++++
 tb/tb_audio_sample_player.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_player.sv
// Buffers processor-written audio samples in a FIFO and plays them out as 1-bit PWM at a fixed rate.
// Optional macro AUDIO_PLAYER_HOLD_LAST_EN: on underflow keep the last sample instead of midscale.
module audio_sample_player #(
  parameter int SAMPLE_W = 11,
  parameter int DEPTH    = 8,
  parameter int CLK_DIV  = 1042
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SAMPLE_W-1:0] i_sample_in,
  input  logic                i_flag_in,
  input  logic                i_enable,
  output logic                o_sample_ack,
  output logic                o_fifo_full,
  output logic                o_fifo_empty,
  output logic                o_overflow,
  output logic                o_underflow,
  output logic [SAMPLE_W-1:0] o_cur_sample,
  output logic                o_pwm_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [SAMPLE_W-1:0] MIDSCALE  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]    COUNT_MAX = CNT_W'(DEPTH);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0]    r_count;
  logic                r_flagQ;
  logic [DIV_W-1:0]    r_divCnt;
  logic [SAMPLE_W-1:0] r_pwmCnt;
  logic [SAMPLE_W-1:0] r_curSample;
  logic                r_ack, r_full, r_empty, r_overflow, r_underflow, r_pwm;

  logic                w_pushReq, w_tick, w_pop, w_push;
  logic [CNT_W-1:0]    w_countNext;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push then.
  assign w_pushReq = i_flag_in & ~r_flagQ;
  assign w_tick    = i_enable & (r_divCnt == DIV_LAST);
  assign w_pop     = w_tick & (r_count != '0);
  assign w_push    = w_pushReq & ((r_count < COUNT_MAX) | w_pop);

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop)
      w_countNext = r_count + CNT_W'(1);
    else if (w_pop && !w_push)
      w_countNext = r_count - CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= i_sample_in;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_flagQ     <= 1'b0;
      r_divCnt    <= '0;
      r_pwmCnt    <= '0;
      r_curSample <= MIDSCALE;
      r_ack       <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_pwm       <= 1'b0;
    end else begin
      r_flagQ <= i_flag_in;
      r_ack   <= w_push;
      r_count <= w_countNext;
      r_full  <= (w_countNext == COUNT_MAX);
      r_empty <= (w_countNext == '0);

      if (w_push)
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pushReq && !w_push)
        r_overflow <= 1'b1;

      // An empty tick is judged on pre-cycle state; a concurrent push cannot satisfy it.
      if (w_pop) begin
        r_curSample <= r_mem[r_rdPtr];
        r_rdPtr     <= r_rdPtr + PTR_W'(1);
      end else if (w_tick) begin
        r_underflow <= 1'b1;
`ifdef AUDIO_PLAYER_HOLD_LAST_EN
        r_curSample <= r_curSample;
`else
        r_curSample <= MIDSCALE;
`endif
      end

      if (!i_enable || r_divCnt == DIV_LAST)
        r_divCnt <= '0;
      else
        r_divCnt <= r_divCnt + DIV_W'(1);

      r_pwmCnt <= i_enable ? r_pwmCnt + SAMPLE_W'(1) : '0;
      r_pwm    <= i_enable & (r_pwmCnt < r_curSample);
    end
  end

  assign o_sample_ack = r_ack;
  assign o_fifo_full  = r_full;
  assign o_fifo_empty = r_empty;
  assign o_overflow   = r_overflow;
  assign o_underflow  = r_underflow;
  assign o_cur_sample = r_curSample;
  assign o_pwm_out    = r_pwm;

endmodule

// File: tb/tb_audio_sample_player.sv
// Directed testbench for audio_sample_player with a short sample period (CLK_DIV=16).
module tb_audio_sample_player;

  localparam int SAMPLE_W = 11;
  localparam int DEPTH    = 8;
  localparam int CLK_DIV  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [SAMPLE_W-1:0] sampleIn;
  logic                flagIn;
  logic                enable;
  logic                sampleAck;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                overflow;
  logic                underflow;
  logic [SAMPLE_W-1:0] curSample;
  logic                pwmOut;

  int checkCount = 0;
  int errorCount = 0;

  audio_sample_player #(
    .SAMPLE_W(SAMPLE_W),
    .DEPTH   (DEPTH),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sample_in (sampleIn),
    .i_flag_in   (flagIn),
    .i_enable    (enable),
    .o_sample_ack(sampleAck),
    .o_fifo_full (fifoFull),
    .o_fifo_empty(fifoEmpty),
    .o_overflow  (overflow),
    .o_underflow (underflow),
    .o_cur_sample(curSample),
    .o_pwm_out   (pwmOut)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst      = 1'b0;
    flagIn   = 1'b0;
    enable   = 1'b0;
    sampleIn = '0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  task automatic pushSample(input logic [SAMPLE_W-1:0] value);
    sampleIn = value;
    flagIn   = 1'b1;
    step();
    flagIn   = 1'b0;
    step();
  endtask

  task automatic test_reset();
    resetDut();
    checkCount++;
    if (fifoEmpty !== 1'b1 || fifoFull !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_fifo: empty=%b full=%b, expected empty=1 full=0", fifoEmpty, fifoFull);
    end
    checkCount++;
    if (curSample !== 11'd1024) begin
      errorCount++;
      $display("[TB] FAIL reset_cur_sample: got %0d, expected 1024", curSample);
    end
    checkCount++;
    if (pwmOut !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || sampleAck !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_flags: pwm=%b ovf=%b udf=%b ack=%b, expected all 0",
               pwmOut, overflow, underflow, sampleAck);
    end
  endtask

  task automatic test_edge_capture();
    int ackTotal;
    resetDut();
    sampleIn = 11'd300;
    flagIn   = 1'b1;
    step();
    checkCount++;
    if (sampleAck !== 1'b1 || fifoEmpty !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL edge_first_ack: ack=%b empty=%b, expected ack=1 empty=0", sampleAck, fifoEmpty);
    end
    ackTotal = (sampleAck === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (sampleAck === 1'b1) ackTotal++;
    end
    flagIn = 1'b0;
    step();
    if (sampleAck === 1'b1) ackTotal++;
    checkCount++;
    if (ackTotal != 1) begin
      errorCount++;
      $display("[TB] FAIL edge_ack_count: got %0d acks, expected 1", ackTotal);
    end
    checkCount++;
    if (fifoEmpty !== 1'b0 || fifoFull !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL edge_count_one: empty=%b full=%b, expected 0 0", fifoEmpty, fifoFull);
    end
    enable = 1'b1;
    repeat (CLK_DIV - 1) step();
    checkCount++;
    if (curSample !== 11'd1024) begin
      errorCount++;
      $display("[TB] FAIL edge_before_tick: got %0d, expected 1024", curSample);
    end
    step();
    checkCount++;
    if (curSample !== 11'd300 || fifoEmpty !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL edge_played: cur=%0d empty=%b, expected 300 and 1", curSample, fifoEmpty);
    end
  endtask

  task automatic test_fifo_fill();
    logic [SAMPLE_W-1:0] prevValue;
    resetDut();
    for (int v = 1; v <= 9; v++) begin
      sampleIn = SAMPLE_W'(v);
      flagIn   = 1'b1;
      step();
      checkCount++;
      if (sampleAck !== (v <= DEPTH)) begin
        errorCount++;
        $display("[TB] FAIL fill_ack_%0d: got %b, expected %b", v, sampleAck, (v <= DEPTH));
      end
      if (v == DEPTH) begin
        checkCount++;
        if (fifoFull !== 1'b1 || overflow !== 1'b0) begin
          errorCount++;
          $display("[TB] FAIL fill_full: full=%b ovf=%b, expected 1 0", fifoFull, overflow);
        end
      end
      flagIn = 1'b0;
      step();
    end
    checkCount++;
    if (overflow !== 1'b1 || fifoFull !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL fill_overflow: ovf=%b full=%b, expected 1 1", overflow, fifoFull);
    end
    enable    = 1'b1;
    prevValue = 11'd1024;
    for (int k = 1; k <= DEPTH; k++) begin
      repeat (CLK_DIV - 1) step();
      checkCount++;
      if (curSample !== prevValue) begin
        errorCount++;
        $display("[TB] FAIL fill_hold_%0d: got %0d, expected %0d", k, curSample, prevValue);
      end
      step();
      checkCount++;
      if (curSample !== SAMPLE_W'(k)) begin
        errorCount++;
        $display("[TB] FAIL fill_play_%0d: got %0d, expected %0d", k, curSample, k);
      end
      prevValue = SAMPLE_W'(k);
    end
    checkCount++;
    if (fifoEmpty !== 1'b1 || underflow !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL fill_drained: empty=%b udf=%b, expected 1 0", fifoEmpty, underflow);
    end
  endtask

  task automatic test_underflow();
    logic [SAMPLE_W-1:0] expectAfter;
`ifdef AUDIO_PLAYER_HOLD_LAST_EN
    expectAfter = 11'd500;
`else
    expectAfter = 11'd1024;
`endif
    resetDut();
    enable = 1'b1;
    repeat (CLK_DIV) step();
    checkCount++;
    if (underflow !== 1'b1 || curSample !== 11'd1024) begin
      errorCount++;
      $display("[TB] FAIL udf_empty: udf=%b cur=%0d, expected 1 1024", underflow, curSample);
    end
    resetDut();
    pushSample(11'd500);
    enable = 1'b1;
    repeat (CLK_DIV) step();
    checkCount++;
    if (curSample !== 11'd500 || underflow !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL udf_play500: cur=%0d udf=%b, expected 500 0", curSample, underflow);
    end
    repeat (CLK_DIV) step();
    checkCount++;
    if (underflow !== 1'b1 || curSample !== expectAfter) begin
      errorCount++;
      $display("[TB] FAIL udf_after500: udf=%b cur=%0d, expected 1 %0d", underflow, curSample, expectAfter);
    end
  endtask

  task automatic test_back_to_back();
    resetDut();
    for (int v = 0; v < DEPTH; v++) pushSample(SAMPLE_W'(10 + v));
    enable = 1'b1;
    repeat (CLK_DIV - 1) step();
    sampleIn = 11'd99;
    flagIn   = 1'b1;
    step();
    checkCount++;
    if (sampleAck !== 1'b1 || fifoFull !== 1'b1 || overflow !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL b2b_push: ack=%b full=%b ovf=%b, expected 1 1 0", sampleAck, fifoFull, overflow);
    end
    checkCount++;
    if (curSample !== 11'd10) begin
      errorCount++;
      $display("[TB] FAIL b2b_pop: got %0d, expected 10", curSample);
    end
    flagIn = 1'b0;
    repeat (CLK_DIV) step();
    checkCount++;
    if (curSample !== 11'd11) begin
      errorCount++;
      $display("[TB] FAIL b2b_next: got %0d, expected 11", curSample);
    end
  endtask

  task automatic test_pwm_duty();
    int highCount;
    resetDut();
    for (int v = 0; v < 4; v++) pushSample(11'd512);
    enable = 1'b1;
    repeat (CLK_DIV) step();
    checkCount++;
    if (curSample !== 11'd512) begin
      errorCount++;
      $display("[TB] FAIL pwm_loaded: got %0d, expected 512", curSample);
    end
    step();
    highCount = 0;
    for (int i = 0; i < 2048; i++) begin
      flagIn = (i % CLK_DIV) == 3;
      if (pwmOut === 1'b1) highCount++;
      step();
    end
    flagIn = 1'b0;
    checkCount++;
    if (highCount != 512) begin
      errorCount++;
      $display("[TB] FAIL pwm_duty: got %0d highs, expected 512", highCount);
    end
    checkCount++;
    if (underflow !== 1'b0 || curSample !== 11'd512) begin
      errorCount++;
      $display("[TB] FAIL pwm_steady: udf=%b cur=%0d, expected 0 512", underflow, curSample);
    end
    rst = 1'b0;
    step();
    checkCount++;
    if (pwmOut !== 1'b0 || fifoEmpty !== 1'b1 || curSample !== 11'd1024) begin
      errorCount++;
      $display("[TB] FAIL pwm_reset: pwm=%b empty=%b cur=%0d, expected 0 1 1024", pwmOut, fifoEmpty, curSample);
    end
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    flagIn   = 1'b0;
    enable   = 1'b0;
    sampleIn = '0;
    test_reset();
    test_edge_capture();
    test_fifo_fill();
    test_underflow();
    test_back_to_back();
    test_pwm_duty();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
